// File: rtl/fifo_ser_tx_if.sv
// fifo_ser_tx_if: FIFO read port and framed serial link of fifo_ser_tx.
// The master side is the transmitter; the slave side is FIFO plus serial device.
interface fifo_ser_tx_if #(
  parameter int unsigned pWidth = 16
);
  logic              FIFO_EF;
  logic [pWidth-1:0] FIFO_DO;
  logic              FIFO_RE;
  logic              SCK;
  logic              SDO;
  logic              nCS;

  modport master (
    input  FIFO_EF,
    input  FIFO_DO,
    output FIFO_RE,
    output SCK,
    output SDO,
    output nCS
  );

  modport slave (
    output FIFO_EF,
    output FIFO_DO,
    input  FIFO_RE,
    input  SCK,
    input  SDO,
    input  nCS
  );
endinterface

// File: rtl/fifo_ser_tx.sv
// fifo_ser_tx: pops words from a first-word-fall-through FIFO and shifts them out
// MSB-first on SCK/SDO/nCS. Define FIFO_SER_TX_PARITY_EN to append an odd-parity bit.
module fifo_ser_tx #(
  parameter int unsigned pWidth = 16,
  parameter int unsigned pDiv   = 4,
  parameter int unsigned pGap   = 2
) (
  input  logic          Clk,
  input  logic          nRst,
  input  logic          En,
  fifo_ser_tx_if.master bus,
  output logic          Busy,
  output logic          Done
);

`ifdef FIFO_SER_TX_PARITY_EN
  localparam int unsigned pBits = pWidth + 1;
`else
  localparam int unsigned pBits = pWidth;
`endif
  localparam int unsigned pDivW = $clog2(pDiv);
  localparam int unsigned pCntW = $clog2(pBits + 1);
  localparam int unsigned pGapW = $clog2(pGap + 2);

  localparam logic [pDivW-1:0] pDivLast = pDivW'(pDiv - 1);
  localparam logic [pDivW-1:0] pDivHalf = pDivW'(pDiv / 2);
  localparam logic [pDivW-1:0] pDivOne  = pDivW'(1);
  localparam logic [pCntW-1:0] pCntLoad = pCntW'(pBits - 1);
  localparam logic [pCntW-1:0] pCntOne  = pCntW'(1);
  localparam logic [pGapW-1:0] pGapLast = pGapW'((pGap > 0) ? (pGap - 1) : 0);
  localparam logic [pGapW-1:0] pGapOne  = pGapW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [pBits-1:0]   shreg_r, shreg_nxt_s;
  logic [pCntW-1:0]   bitcnt_r, bitcnt_nxt_s;
  logic [pDivW-1:0]   div_r, div_nxt_s;
  logic [pGapW-1:0]   gap_r, gap_nxt_s;
  logic               sck_r, sck_nxt_s;
  logic               sdo_r, sdo_nxt_s;
  logic               ncs_r, ncs_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic [pBits-1:0]   load_word_s;

`ifdef FIFO_SER_TX_PARITY_EN
  // Odd parity: the extra bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [pWidth-1:0] d);
    return ~^d;
  endfunction

  assign load_word_s = {bus.FIFO_DO, odd_parity(bus.FIFO_DO)};
`else
  assign load_word_s = bus.FIFO_DO;
`endif

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    state_nxt_s  = state_r;
    shreg_nxt_s  = shreg_r;
    bitcnt_nxt_s = bitcnt_r;
    div_nxt_s    = div_r;
    gap_nxt_s    = gap_r;
    sck_nxt_s    = 1'b0;
    sdo_nxt_s    = sdo_r;
    ncs_nxt_s    = ncs_r;
    done_nxt_s   = 1'b0;

    case (state_r)
      IDLE: begin
        ncs_nxt_s = 1'b1;
        if (En && !bus.FIFO_EF) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      LOAD: begin
        shreg_nxt_s  = load_word_s;
        bitcnt_nxt_s = pCntLoad;
        div_nxt_s    = '0;
        ncs_nxt_s    = 1'b0;
        sdo_nxt_s    = load_word_s[pBits-1];
        state_nxt_s  = SHIFT;
      end

      SHIFT: begin
        if (div_r == pDivLast) begin
          div_nxt_s = '0;
          if (bitcnt_r != '0) begin
            // SDO moves on the SCK falling edge that closes this bit period.
            shreg_nxt_s  = shreg_r << 1'b1;
            bitcnt_nxt_s = bitcnt_r - pCntOne;
            sdo_nxt_s    = shreg_r[pBits-2];
          end else begin
            ncs_nxt_s  = 1'b1;
            done_nxt_s = 1'b1;
            gap_nxt_s  = '0;
            if (pGap == 32'd0) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = GAP;
            end
          end
        end else begin
          div_nxt_s = div_r + pDivOne;
          sck_nxt_s = (div_nxt_s >= pDivHalf);
        end
      end

      GAP: begin
        ncs_nxt_s = 1'b1;
        if (gap_r == pGapLast) begin
          state_nxt_s = IDLE;
        end else begin
          gap_nxt_s = gap_r + pGapOne;
        end
      end

      default: begin
        state_nxt_s = IDLE;
        ncs_nxt_s   = 1'b1;
      end
    endcase

    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State, datapath and output registers; nRst aborts any frame immediately.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_r  <= IDLE;
      shreg_r  <= '0;
      bitcnt_r <= '0;
      div_r    <= '0;
      gap_r    <= '0;
      sck_r    <= 1'b0;
      sdo_r    <= 1'b0;
      ncs_r    <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      shreg_r  <= shreg_nxt_s;
      bitcnt_r <= bitcnt_nxt_s;
      div_r    <= div_nxt_s;
      gap_r    <= gap_nxt_s;
      sck_r    <= sck_nxt_s;
      sdo_r    <= sdo_nxt_s;
      ncs_r    <= ncs_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign bus.FIFO_RE = (state_r == LOAD);
  assign bus.SCK     = sck_r;
  assign bus.SDO     = sdo_r;
  assign bus.nCS     = ncs_r;
  assign Busy        = busy_r;
  assign Done        = done_r;

endmodule

// File: tb/tb_fifo_ser_tx.sv
// tb_fifo_ser_tx: FIFO model plus scoreboard; a monitor decodes each serial frame
// and compares it with the word queued when stimulus pushed it.
module tb_fifo_ser_tx;
  localparam int P_WIDTH = 16;
  localparam int P_DIV   = 4;
  localparam int P_GAP   = 2;
`ifdef FIFO_SER_TX_PARITY_EN
  localparam int NB = P_WIDTH + 1;
`else
  localparam int NB = P_WIDTH;
`endif

  logic Clk = 1'b0;
  logic nRst;
  logic En;
  logic Busy;
  logic Done;

  fifo_ser_tx_if #(.pWidth(P_WIDTH)) bus ();

  fifo_ser_tx #(.pWidth(P_WIDTH), .pDiv(P_DIV), .pGap(P_GAP)) dut (
    .Clk  (Clk),
    .nRst (nRst),
    .En   (En),
    .bus  (bus.master),
    .Busy (Busy),
    .Done (Done)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int errs  = 0;

  logic [P_WIDTH-1:0] fifo_q[$];
  logic [P_WIDTH-1:0] exp_q[$];
  int                 gap_q[$];
  int re_cnt = 0;
  int done_cnt = 0;
  int frames_seen = 0;

  logic          in_frame = 1'b0;
  logic          sck_prev = 1'b0;
  logic [NB-1:0] mon_word = '0;
  int            mon_nbits = 0;
  int            low_cnt = 0;
  int            hi_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] exp_bits(input logic [P_WIDTH-1:0] w);
`ifdef FIFO_SER_TX_PARITY_EN
    return {w, ~^w};
`else
    return w;
`endif
  endfunction

  task automatic push(input logic [P_WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (frames_seen < target && n < 400) begin
      @(negedge Clk);
      n++;
    end
    chk(name, 32'(frames_seen >= target), 32'd1);
  endtask

  // FIFO model: pop on each read strobe, present flags half a cycle later.
  always @(posedge Clk) begin
    if (nRst && bus.FIFO_RE) begin
      re_cnt++;
      chk("no_underflow", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
  end

  always @(negedge Clk) begin
    bus.FIFO_EF = (fifo_q.size() == 0);
    bus.FIFO_DO = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  end

  // Monitor: collect SDO on SCK rising edges; score each frame when nCS rises.
  always @(negedge Clk) begin
    if (!nRst) begin
      in_frame = 1'b0;
      sck_prev = 1'b0;
      hi_cnt   = 0;
    end else begin
      if (Done) done_cnt++;
      if (!bus.nCS) begin
        if (!in_frame) begin
          in_frame  = 1'b1;
          gap_q.push_back(hi_cnt);
          low_cnt   = 0;
          mon_nbits = 0;
          mon_word  = '0;
        end
        low_cnt++;
        if (bus.SCK && !sck_prev) begin
          mon_word = {mon_word[NB-2:0], bus.SDO};
          mon_nbits++;
        end
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          hi_cnt   = 0;
          if (exp_q.size() == 0) begin
            chk("frame_expected", 32'd0, 32'd1);
          end else begin
            logic [P_WIDTH-1:0] w;
            w = exp_q.pop_front();
            chk("frame_bits", 32'(mon_word), 32'(exp_bits(w)));
          end
          chk("frame_nbits", 32'(mon_nbits), 32'(NB));
          chk("frame_ncs_low", 32'(low_cnt), 32'(NB * P_DIV));
          chk("frame_done", 32'(Done), 32'd1);
          frames_seen++;
        end
        hi_cnt++;
      end
      sck_prev = bus.SCK;
    end
  end

  initial begin
    int r0, d0, f0, n, busy_seen, low_seen;
    nRst = 1'b0;
    En   = 1'b1;

    // Reset state with a word waiting and En high.
    push(16'hA5C3);
    repeat (3) @(negedge Clk);
    chk("rst_fifo_re", 32'(bus.FIFO_RE), 32'd0);
    chk("rst_ncs", 32'(bus.nCS), 32'd1);
    chk("rst_sck", 32'(bus.SCK), 32'd0);
    chk("rst_sdo", 32'(bus.SDO), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    @(posedge Clk);
    #1 nRst = 1'b1;
    @(posedge Clk);
    #1 chk("first_re_after_release", 32'(bus.FIFO_RE), 32'd1);

    // Single frame A5C3, then Busy drops pGap cycles after Done.
    n = 0;
    while (!Done && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("t2_done_seen", 32'(Done), 32'd1);
    chk("t2_busy_in_gap", 32'(Busy), 32'd1);
    @(negedge Clk);
    chk("t2_busy_gap_end", 32'(Busy), 32'd1);
    @(negedge Clk);
    chk("t2_busy_idle", 32'(Busy), 32'd0);
    chk("t2_re_count", 32'(re_cnt), 32'd1);
    chk("t2_done_count", 32'(done_cnt), 32'd1);

    // Three back-to-back words.
    gap_q.delete();
    r0 = re_cnt;
    push(16'h1111);
    push(16'h2222);
    push(16'h8001);
    wait_frames(4, "t3_frames");
    chk("t3_re_count", 32'(re_cnt - r0), 32'd3);
    chk("t3_fifo_empty", 32'(bus.FIFO_EF), 32'd1);
    chk("t3_gap_count", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
      chk("t3_gap1", 32'(gap_q[1]), 32'(P_GAP + 2));
      chk("t3_gap2", 32'(gap_q[2]), 32'(P_GAP + 2));
    end

    // Empty FIFO with En held: nothing may happen.
    repeat (5) @(negedge Clk);
    r0 = re_cnt;
    busy_seen = 0;
    low_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Busy) busy_seen++;
      if (!bus.nCS) low_seen++;
    end
    chk("t4_no_re", 32'(re_cnt - r0), 32'd0);
    chk("t4_ncs_high", 32'(low_seen), 32'd0);
    chk("t4_not_busy", 32'(busy_seen), 32'd0);

    // En dropped mid-frame: frame completes, no second pop.
    r0 = re_cnt;
    push(16'h6C39);
    push(16'h01FE);
    n = 0;
    while (!(in_frame && mon_nbits >= 5) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    En = 1'b0;
    wait_frames(5, "t5_frame");
    repeat (30) @(negedge Clk);
    chk("t5_one_pop", 32'(re_cnt - r0), 32'd1);
    chk("t5_fifo_cnt", 32'(fifo_q.size()), 32'd1);

    // Reset during bit 8 of the next frame aborts it without Done.
    En = 1'b1;
    n = 0;
    while (!(in_frame && mon_nbits >= 8) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    d0 = done_cnt;
    f0 = frames_seen;
    nRst = 1'b0;
    #1;
    chk("t6_abort_ncs", 32'(bus.nCS), 32'd1);
    chk("t6_abort_sck", 32'(bus.SCK), 32'd0);
    chk("t6_abort_sdo", 32'(bus.SDO), 32'd0);
    chk("t6_abort_busy", 32'(Busy), 32'd0);
    chk("t6_abort_done", 32'(Done), 32'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    push(16'h0F0F);
    repeat (3) @(negedge Clk);
    nRst = 1'b1;
    repeat (2) @(negedge Clk);
    chk("t6_no_done_pulse", 32'(done_cnt - d0), 32'd0);
    chk("t6_no_frame_scored", 32'(frames_seen - f0), 32'd0);
    wait_frames(f0 + 1, "t6_next_frame");
    repeat (10) @(negedge Clk);
    chk("all_frames_delivered", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
